dmem_access_ctrl: RTL and testbench

Sequences every data-memory access of the RV32I core. Accepts one load/store from the execute stage, runs the request/grant/response handshake on the data-memory bus, generates lane-aligned write data and byte masks, and stalls the pipeline until completion. For loads it captures the returned word and holds the size, signedness and address-LSB controls stable for the load extraction unit.

---
 rtl/dmem_access_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//
// Data-memory access sequencer for the RV32I core. It accepts one load or
// store from the execute stage and runs the request/grant/response handshake
// on the data-memory bus. It builds lane-replicated write data and byte
// masks, and stalls the pipeline until the access completes or is aborted.
// Load data, size, signedness and address LSBs are held stable for the load
// extraction unit until the next accepted access.
//
// Parameters:
//   TIMEOUT_CYCLES    cycles an access may stay outstanding before it is
//                     aborted (0 disables the timeout)
//
// Build option:
//   MISALIGN_TRAP_EN  when defined, a misaligned half or word access is
//                     trapped (no bus cycle, misalign_err_out pulse). When
//                     not defined, misalign_err_out is tied low and the
//                     offending address LSBs are discarded.
//
// Ports:
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   lsu_*_in                access request from the execute stage
//   lsu_done_out            one-cycle completion pulse
//   stall_out               pipeline stall
//   bus_err_out             one-cycle timeout pulse
//   misalign_err_out        one-cycle misaligned-access pulse
//   dm_*_out / dm_*_in      data-memory bus (req/gnt, rvalid/rdata)
//   dmdata_out              captured load word
//   load_size_out, load_unsigned_out, addr_1_to_0_out
//                           held controls for the load unit

module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        lsu_valid_in,
    input  logic        lsu_store_in,
    input  logic [31:0] lsu_addr_in,
    input  logic [31:0] lsu_wdata_in,
    input  logic [1:0]  lsu_size_in,
    input  logic        lsu_unsigned_in,
    output logic        lsu_done_out,
    output logic        stall_out,
    output logic        bus_err_out,
    output logic        misalign_err_out,
    output logic        dm_req_out,
    output logic        dm_we_out,
    output logic [31:0] dm_addr_out,
    output logic [31:0] dm_wdata_out,
    output logic [3:0]  dm_wmask_out,
    input  logic        dm_gnt_in,
    input  logic        dm_rvalid_in,
    input  logic [31:0] dm_rdata_in,
    output logic [31:0] dmdata_out,
    output logic [1:0]  load_size_out,
    output logic        load_unsigned_out,
    output logic [1:0]  addr_1_to_0_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic [31:0] tmo_cnt;

    logic        store_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  mask_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  lsb_q;
    logic [31:0] rdata_q;

    logic        done_q;
    logic        bus_err_q;
    logic        misalign_q;

    logic [3:0]  acc_mask;
    logic [31:0] acc_wdata;
    logic        trap;
    logic        timeout_hit;

    // Lane mask and replicated write data for the incoming request.
    always_comb begin
        acc_mask  = '0;
        acc_wdata = lsu_wdata_in;
        case (lsu_size_in)
            2'b00: begin
                acc_mask  = 4'b0001 << lsu_addr_in[1:0];
                acc_wdata = {4{lsu_wdata_in[7:0]}};
            end
            2'b01: begin
                acc_mask  = 4'b0011 << {lsu_addr_in[1], 1'b0};
                acc_wdata = {2{lsu_wdata_in[15:0]}};
            end
            default: begin
                acc_mask  = 4'b1111;
                acc_wdata = lsu_wdata_in;
            end
        endcase
        if (!lsu_store_in) begin
            acc_mask = '0;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        trap = ((lsu_size_in == 2'b01) && lsu_addr_in[0]) ||
               (lsu_size_in[1] && (lsu_addr_in[1:0] != 2'b00));
    end
`else
    always_comb begin
        trap = 1'b0;
    end
`endif

    // The counter holds the number of completed outstanding cycles, so the
    // abort fires at the end of the TIMEOUT_CYCLES-th cycle in REQ/RESP.
    always_comb begin
        timeout_hit = (TIMEOUT_CYCLES != 0) &&
                      (tmo_cnt == (TIMEOUT_CYCLES - 32'd1));
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            store_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            lsb_q      <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            bus_err_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            bus_err_q  <= 1'b0;
            misalign_q <= 1'b0;

            if ((state != IDLE) && (TIMEOUT_CYCLES != 0)) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end

            case (state)
                IDLE: begin
                    if (lsu_valid_in) begin
                        store_q    <= lsu_store_in;
                        addr_q     <= {lsu_addr_in[31:2], 2'b00};
                        wdata_q    <= acc_wdata;
                        mask_q     <= acc_mask;
                        size_q     <= lsu_size_in;
                        unsigned_q <= lsu_unsigned_in;
                        lsb_q      <= lsu_addr_in[1:0];
                        tmo_cnt    <= '0;
                        if (trap) begin
                            misalign_q <= 1'b1;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    // Completion wins over a timeout landing on the same cycle.
                    if (dm_gnt_in) begin
                        if (store_q) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            state <= RESP;
                        end
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        bus_err_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (dm_rvalid_in) begin
                        rdata_q <= dm_rdata_in;
                        done_q  <= 1'b1;
                        state   <= IDLE;
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        bus_err_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Request and write enable follow the state register directly so that
    // an asynchronous reset removes them immediately.
    assign dm_req_out        = (state == REQ);
    assign dm_we_out         = (state == REQ) && store_q;
    assign dm_addr_out       = addr_q;
    assign dm_wdata_out      = wdata_q;
    assign dm_wmask_out      = mask_q;

    assign stall_out         = (state != IDLE) || lsu_valid_in;
    assign lsu_done_out      = done_q;
    assign bus_err_out       = bus_err_q;
    assign misalign_err_out  = misalign_q;

    assign dmdata_out        = rdata_q;
    assign load_size_out     = size_q;
    assign load_unsigned_out = unsigned_q;
    assign addr_1_to_0_out   = lsb_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed vector table,
// hand-written reset-during-response sequence, and randomized accesses
// checked against a cycle-count model of the handshake.

module tb_dmem_access_ctrl;

    localparam int TO = 8;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b1;
    logic        lsu_valid_in = 1'b0;
    logic        lsu_store_in = 1'b0;
    logic [31:0] lsu_addr_in = '0;
    logic [31:0] lsu_wdata_in = '0;
    logic [1:0]  lsu_size_in = '0;
    logic        lsu_unsigned_in = 1'b0;
    logic        lsu_done_out;
    logic        stall_out;
    logic        bus_err_out;
    logic        misalign_err_out;
    logic        dm_req_out;
    logic        dm_we_out;
    logic [31:0] dm_addr_out;
    logic [31:0] dm_wdata_out;
    logic [3:0]  dm_wmask_out;
    logic        dm_gnt_in = 1'b0;
    logic        dm_rvalid_in = 1'b0;
    logic [31:0] dm_rdata_in = '0;
    logic [31:0] dmdata_out;
    logic [1:0]  load_size_out;
    logic        load_unsigned_out;
    logic [1:0]  addr_1_to_0_out;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .lsu_valid_in(lsu_valid_in), .lsu_store_in(lsu_store_in),
        .lsu_addr_in(lsu_addr_in), .lsu_wdata_in(lsu_wdata_in),
        .lsu_size_in(lsu_size_in), .lsu_unsigned_in(lsu_unsigned_in),
        .lsu_done_out(lsu_done_out), .stall_out(stall_out),
        .bus_err_out(bus_err_out), .misalign_err_out(misalign_err_out),
        .dm_req_out(dm_req_out), .dm_we_out(dm_we_out),
        .dm_addr_out(dm_addr_out), .dm_wdata_out(dm_wdata_out),
        .dm_wmask_out(dm_wmask_out), .dm_gnt_in(dm_gnt_in),
        .dm_rvalid_in(dm_rvalid_in), .dm_rdata_in(dm_rdata_in),
        .dmdata_out(dmdata_out), .load_size_out(load_size_out),
        .load_unsigned_out(load_unsigned_out), .addr_1_to_0_out(addr_1_to_0_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_dmdata = '0;

    typedef struct {
        logic        st;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  sz;
        logic        un;
        int          gd;
        int          rd;
        logic [31:0] rdat;
        logic [31:0] e_addr;
        logic [3:0]  e_mask;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        if (sz == 2'd0) return 1;
        if (sz == 2'd1) return 2;
        return 4;
    endfunction

    // Bytes touched: a byte at addr%4, a half at its even-aligned pair, a word at all four.
    function automatic logic [3:0] model_mask(input logic st, input logic [31:0] addr, input logic [1:0] sz);
        logic [3:0] r;
        int nb;
        int first;
        r = '0;
        if (!st) return r;
        nb = nbytes(sz);
        if (nb == 1) first = int'(addr % 4);
        else if (nb == 2) first = int'((addr % 4) / 2) * 2;
        else first = 0;
        for (int i = 0; i < nb; i++) r[first + i] = 1'b1;
        return r;
    endfunction

    // Each byte lane repeats the low nbytes of the store data.
    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] sz);
        logic [31:0] r;
        int nb;
        nb = nbytes(sz);
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic bit model_misaligned(input logic [31:0] addr, input logic [1:0] sz);
        int nb;
        nb = nbytes(sz);
        return (addr % nb) != 0;
    endfunction

    // Runs one access starting in the current cycle slot. Grant arrives in
    // outstanding cycle gd+1, rvalid rd cycles after the cycle following it.
    // Returns in the done/abort cycle with all inputs idle.
    task automatic run_access(input logic st, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [1:0] sz, input logic un, input int gd, input int rd,
                              input logic [31:0] rdat, input logic [31:0] e_addr,
                              input logic [3:0] e_mask, input logic [31:0] e_wdata);
        int g;
        int v;
        bit fin;
        bit mis;
        g = gd + 1;
        v = g + 1 + rd;
        fin = 0;
        mis = 0;
`ifdef MISALIGN_TRAP_EN
        mis = model_misaligned(addr, sz);
`endif
        lsu_valid_in = 1'b1;
        lsu_store_in = st;
        lsu_addr_in = addr;
        lsu_wdata_in = wd;
        lsu_size_in = sz;
        lsu_unsigned_in = un;
        dm_gnt_in = 1'b0;
        dm_rvalid_in = 1'b0;
        #1;
        check("accept_stall", stall_out, 1);
        check("accept_req", dm_req_out, 0);
        tick();
        lsu_valid_in = 1'b0;
        lsu_wdata_in = $urandom;
        if (mis) begin
            #1;
            check("trap_misalign", misalign_err_out, 1);
            check("trap_req", dm_req_out, 0);
            check("trap_done", lsu_done_out, 0);
            check("trap_stall", stall_out, 0);
            return;
        end
        for (int k = 1; k <= TO; k++) begin
            dm_gnt_in = (k == g);
            dm_rvalid_in = !st && (k == v);
            dm_rdata_in = (k == v) ? rdat : $urandom;
            #1;
            check("busy_req", dm_req_out, (k <= g) ? 1 : 0);
            check("busy_stall", stall_out, 1);
            check("busy_done", lsu_done_out, 0);
            check("busy_buserr", bus_err_out, 0);
            check("busy_misalign", misalign_err_out, 0);
            if (k <= g) begin
                check("req_we", dm_we_out, st);
                check("req_addr", dm_addr_out, e_addr);
                check("req_mask", dm_wmask_out, e_mask);
                if (st) check("req_wdata", dm_wdata_out, e_wdata);
            end
            tick();
            if ((st && k == g) || (!st && k == v)) begin
                fin = 1;
                break;
            end
        end
        dm_gnt_in = 1'b0;
        dm_rvalid_in = 1'b0;
        #1;
        if (fin) begin
            check("end_done", lsu_done_out, 1);
            check("end_buserr", bus_err_out, 0);
            if (!st) exp_dmdata = rdat;
        end else begin
            check("end_done", lsu_done_out, 0);
            check("end_buserr", bus_err_out, 1);
        end
        check("end_req", dm_req_out, 0);
        check("end_stall", stall_out, 0);
        check("end_dmdata", dmdata_out, exp_dmdata);
        check("end_size", load_size_out, sz);
        check("end_unsigned", load_unsigned_out, un);
        check("end_lsb", addr_1_to_0_out, addr[1:0]);
    endtask

    initial begin
        //         st    addr          wd            sz  un  gd   rd  rdat          e_addr        e_mask   e_wdata
        vecs[0]  = '{1'b0, 32'h0000_1000, 32'h0,        2'd2, 1'b0, 0,   0, 32'hDEAD_BEEF, 32'h0000_1000, 4'b0000, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_2003, 32'h0000_00A5, 2'd0, 1'b0, 0,   0, 32'h0,        32'h0000_2000, 4'b1000, 32'hA5A5_A5A5};
        vecs[2]  = '{1'b1, 32'h0000_0102, 32'h1234_BEEF, 2'd1, 1'b0, 5,   0, 32'h0,        32'h0000_0100, 4'b1100, 32'hBEEF_BEEF};
        vecs[3]  = '{1'b1, 32'h0000_3004, 32'hCAFE_F00D, 2'd3, 1'b0, 1,   0, 32'h0,        32'h0000_3004, 4'b1111, 32'hCAFE_F00D};
        vecs[4]  = '{1'b0, 32'h0000_1002, 32'h0,        2'd1, 1'b1, 2,   1, 32'h8001_7F02, 32'h0000_1000, 4'b0000, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_1002, 32'h0,        2'd2, 1'b0, 0,   0, 32'h1357_2468, 32'h0000_1000, 4'b0000, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0101, 32'h0000_ABCD, 2'd1, 1'b0, 0,   0, 32'h0,        32'h0000_0100, 4'b0011, 32'hABCD_ABCD};
        vecs[7]  = '{1'b1, 32'h0000_0001, 32'hFFFF_FF3C, 2'd0, 1'b0, 7,   0, 32'h0,        32'h0000_0000, 4'b0010, 32'h3C3C_3C3C};
        vecs[8]  = '{1'b1, 32'h0000_5000, 32'h1111_2222, 2'd2, 1'b0, 100, 0, 32'h0,        32'h0000_5000, 4'b1111, 32'h1111_2222};
        vecs[9]  = '{1'b0, 32'h0000_6001, 32'h0,        2'd0, 1'b0, 1,   5, 32'h0BAD_F00D, 32'h0000_6000, 4'b0000, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_7000, 32'h0,        2'd2, 1'b0, 1,   6, 32'h7777_7777, 32'h0000_7000, 4'b0000, 32'h0};
        vecs[11] = '{1'b1, 32'h0000_2002, 32'h0000_005A, 2'd0, 1'b0, 3,   0, 32'h0,        32'h0000_2000, 4'b0100, 32'h5A5A_5A5A};

        // Reset state
        #1 rst_n_in = 1'b0;
        #2;
        check("rst_req", dm_req_out, 0);
        check("rst_we", dm_we_out, 0);
        check("rst_done", lsu_done_out, 0);
        check("rst_stall", stall_out, 0);
        check("rst_buserr", bus_err_out, 0);
        check("rst_misalign", misalign_err_out, 0);
        check("rst_addr", dm_addr_out, 0);
        check("rst_wdata", dm_wdata_out, 0);
        check("rst_mask", dm_wmask_out, 0);
        check("rst_dmdata", dmdata_out, 0);
        check("rst_ctrl", {load_size_out, load_unsigned_out, addr_1_to_0_out}, 0);
        tick();
        tick();
        rst_n_in = 1'b1;

        // Directed vector table (back-to-back: each access starts in the
        // done/abort cycle of the previous one)
        for (int i = 0; i < 12; i++) begin
            run_access(vecs[i].st, vecs[i].addr, vecs[i].wd, vecs[i].sz, vecs[i].un,
                       vecs[i].gd, vecs[i].rd, vecs[i].rdat, vecs[i].e_addr,
                       vecs[i].e_mask, vecs[i].e_wdata);
        end
        tick();
        #1;
        check("post_done_pulse", lsu_done_out, 0);

        // Reset asserted while waiting for read data, rvalid after release
        lsu_valid_in = 1'b1;
        lsu_store_in = 1'b0;
        lsu_addr_in = 32'h0000_4002;
        lsu_size_in = 2'd1;
        lsu_unsigned_in = 1'b1;
        tick();
        lsu_valid_in = 1'b0;
        dm_gnt_in = 1'b1;
        tick();
        dm_gnt_in = 1'b0;
        #1;
        check("resp_req", dm_req_out, 0);
        check("resp_stall", stall_out, 1);
        rst_n_in = 1'b0;
        #1;
        check("midrst_req", dm_req_out, 0);
        check("midrst_stall", stall_out, 0);
        check("midrst_dmdata", dmdata_out, 0);
        check("midrst_ctrl", {load_size_out, load_unsigned_out, addr_1_to_0_out}, 0);
        check("midrst_addr", dm_addr_out, 0);
        tick();
        rst_n_in = 1'b1;
        dm_rvalid_in = 1'b1;
        dm_rdata_in = 32'hFEED_FACE;
        tick();
        dm_rvalid_in = 1'b0;
        #1;
        check("late_rvalid_done", lsu_done_out, 0);
        check("late_rvalid_dmdata", dmdata_out, 0);
        check("late_rvalid_stall", stall_out, 0);
        exp_dmdata = '0;
        tick();
        #1;
        check("late_rvalid_done2", lsu_done_out, 0);

        // Randomized accesses against the model
        for (int n = 0; n < 60; n++) begin
            logic        st;
            logic [31:0] addr;
            logic [31:0] wd;
            logic [1:0]  sz;
            st = 1'($urandom_range(0, 1));
            addr = $urandom;
            wd = $urandom;
            sz = 2'($urandom_range(0, 3));
            run_access(st, addr, wd, sz, 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), $urandom,
                       {addr[31:2], 2'b00}, model_mask(st, addr, sz), model_wdata(wd, sz));
            if ($urandom_range(0, 1) == 1) begin
                dm_rvalid_in = 1'b1;
                dm_rdata_in = $urandom;
                tick();
                dm_rvalid_in = 1'b0;
                #1;
                check("idle_rvalid_dmdata", dmdata_out, exp_dmdata);
                check("idle_rvalid_done", lsu_done_out, 0);
                check("idle_buserr", bus_err_out, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
